// File: rtl/aes_key_scheduler.sv
// On-the-fly AES-128 round-key generator.
// Produces one round key per request by time-sharing an external synchronous
// S-box: the four SubWord lookups are issued one byte per cycle, then the
// whole next key is formed in a single combinational step.
module aes_key_scheduler #(
  parameter int NROUNDS = 10
) (
  input  logic         int_osc,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         add,
  output logic [7:0]   sbox_addr,
  input  logic [7:0]   sbox_data,
  output logic [127:0] nextkey,
  output logic         complete,
  output logic [3:0]   round,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE,
    READY,
    SUB0,
    SUB1,
    SUB2,
    SUB3,
    CAP,
    CALC
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] subword;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3;
  logic [31:0] temp;
  logic [31:0] w4, w5, w6, w7;
  logic        can_advance;

  // Round constant for a 1-based round index: 01 doubled in GF(2^8) per round.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 2; i < 16; i++) begin
      if (i <= int'(idx)) begin
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
    end
    return rc;
  endfunction

  assign w0     = nextkey[127:96];
  assign w1     = nextkey[95:64];
  assign w2     = nextkey[63:32];
  assign w3     = nextkey[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  // The last round key is held once reached; further requests do nothing.
  assign can_advance = (round < 4'(NROUNDS));

  assign temp = subword ^ {rcon_of(round + 4'd1), 24'h000000};
  assign w4   = w0 ^ temp;
  assign w5   = w1 ^ w4;
  assign w6   = w2 ^ w5;
  assign w7   = w3 ^ w6;

  // State register.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and outputs; start overrides everything, including add.
  always_comb begin
    state_next = state;
    sbox_addr  = 8'h00;
    complete   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      READY: begin
        complete = 1'b1;
        if (add && can_advance) begin
          state_next = SUB0;
        end
      end
      SUB0: begin
        busy       = 1'b1;
        sbox_addr  = rot_w3[31:24];
        state_next = SUB1;
      end
      SUB1: begin
        busy       = 1'b1;
        sbox_addr  = rot_w3[23:16];
        state_next = SUB2;
      end
      SUB2: begin
        busy       = 1'b1;
        sbox_addr  = rot_w3[15:8];
        state_next = SUB3;
      end
      SUB3: begin
        busy       = 1'b1;
        sbox_addr  = rot_w3[7:0];
        state_next = CAP;
      end
      CAP: begin
        busy       = 1'b1;
        sbox_addr  = rot_w3[7:0];
        state_next = CALC;
      end
      CALC: begin
        busy       = 1'b1;
        state_next = READY;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (start) begin
      state_next = READY;
    end
  end

  // S-box results arrive one cycle after their address, so each byte is
  // taken on the edge leaving the state after the one that issued it.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      subword <= 32'h0;
    end else begin
      case (state)
        SUB1:    subword[31:24] <= sbox_data;
        SUB2:    subword[23:16] <= sbox_data;
        SUB3:    subword[15:8]  <= sbox_data;
        CAP:     subword[7:0]   <= sbox_data;
        default: subword        <= subword;
      endcase
    end
  end

  // Round key and index: reload on start, advance only when leaving CALC.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      nextkey <= 128'h0;
      round   <= 4'd0;
    end else if (start) begin
      nextkey <= key;
      round   <= 4'd0;
    end else if (state == CALC) begin
      nextkey <= {w4, w5, w6, w7};
      round   <= round + 4'd1;
    end
  end

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Self-checking bench for aes_key_scheduler: a behavioural model built on a
// plain FIPS-197 key expansion tracks what every output must be each cycle,
// while directed sequences pin known vectors and corner cases.
module tb_aes_key_scheduler;

  localparam int NROUNDS = 10;

  logic         int_osc;
  logic         reset;
  logic         start;
  logic [127:0] key;
  logic         add;
  logic [7:0]   sbox_addr;
  logic [7:0]   sbox_data;
  logic [127:0] nextkey;
  logic         complete;
  logic [3:0]   round;
  logic         busy;

  int n_compared;
  int n_mismatched;

  logic [7:0] sbox_tab [0:255];

  aes_key_scheduler #(.NROUNDS(NROUNDS)) dut (
    .int_osc  (int_osc),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .add      (add),
    .sbox_addr(sbox_addr),
    .sbox_data(sbox_data),
    .nextkey  (nextkey),
    .complete (complete),
    .round    (round),
    .busy     (busy)
  );

  // 10-unit clock period.
  initial int_osc = 1'b0;
  always #5 int_osc = ~int_osc;

  // External synchronous S-box: one cycle of latency.
  always @(posedge int_osc) sbox_data <= sbox_tab[sbox_addr];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] s;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  // Textbook key expansion: round key r of the given cipher key.
  function automatic logic [127:0] expand(input logic [127:0] ck, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = ck[127:96];
    w[1] = ck[95:64];
    w[2] = ck[63:32];
    w[3] = ck[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [127:0] k);
    start = s;
    add   = a;
    key   = k;
  endtask

  task automatic tick();
    @(posedge int_osc);
    #2;
  endtask

  // Behavioural model: current key, round and cycles left in a computation.
  logic         m_started;
  logic [127:0] m_cipher;
  logic [127:0] m_key;
  logic [127:0] m_pending;
  int           m_round;
  int           m_count;

  always @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      m_started <= 1'b0;
      m_key     <= 128'h0;
      m_round   <= 0;
      m_count   <= 0;
    end else if (start) begin
      m_started <= 1'b1;
      m_cipher  <= key;
      m_key     <= key;
      m_round   <= 0;
      m_count   <= 0;
    end else if (m_count != 0) begin
      m_count <= m_count - 1;
      if (m_count == 1) begin
        m_key   <= m_pending;
        m_round <= m_round + 1;
      end
    end else if (m_started && add && m_round < NROUNDS) begin
      m_count   <= 6;
      m_pending <= expand(m_cipher, m_round + 1);
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge int_osc) begin
    logic [31:0] rw;
    logic [7:0]  exp_addr;
    int          k;
    rw = {m_key[23:0], m_key[31:24]};
    exp_addr = 8'h00;
    if (m_count >= 2) begin
      k = (m_count >= 3) ? (6 - m_count) : 3;
      exp_addr = rw[31-8*k -: 8];
    end
    checkOutput("nextkey", nextkey, m_key);
    checkOutput("round", {124'h0, round}, 128'(m_round));
    checkOutput("complete", {127'h0, complete}, {127'h0, (m_started && m_count == 0)});
    checkOutput("busy", {127'h0, busy}, {127'h0, (m_count != 0)});
    checkOutput("sbox_addr", {120'h0, sbox_addr}, {120'h0, exp_addr});
  end

  task automatic waitComplete(input string name);
    int n;
    n = 0;
    while (!complete && n < 20) begin
      tick();
      n++;
    end
    if (!complete) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: timeout waiting for complete, got 0, expected 1", name);
    end
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ABORT_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    logic [7:0] addr_seq [0:3];
    logic [7:0] exp_seq  [0:3];
    int cycles;

    n_compared   = 0;
    n_mismatched = 0;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    sbox_data = 8'h00;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 128'h0);
    exp_seq[0] = 8'hcf;
    exp_seq[1] = 8'h4f;
    exp_seq[2] = 8'h3c;
    exp_seq[3] = 8'h09;

    // Reset state, then idle without start.
    tick();
    tick();
    checkOutput("reset_nextkey", nextkey, 128'h0);
    reset = 1'b1;
    repeat (4) tick();
    checkOutput("idle_complete", {127'h0, complete}, 128'h0);

    // FIPS-197 key, single request, S-box address sequence.
    applyStimulus(1'b1, 1'b0, FIPS_KEY);
    tick();
    applyStimulus(1'b0, 1'b0, 128'h0);
    checkOutput("load_key", nextkey, FIPS_KEY);
    checkOutput("load_complete", {127'h0, complete}, 128'h1);
    applyStimulus(1'b0, 1'b1, 128'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 128'h0);
    for (int i = 0; i < 4; i++) begin
      addr_seq[i] = sbox_addr;
      tick();
    end
    for (int i = 0; i < 4; i++) checkOutput("sbox_seq", {120'h0, addr_seq[i]}, {120'h0, exp_seq[i]});
    checkOutput("cap_busy", {127'h0, busy}, 128'h1);
    tick();
    checkOutput("calc_complete", {127'h0, complete}, 128'h0);
    tick();
    checkOutput("r1_complete", {127'h0, complete}, 128'h1);
    checkOutput("r1_round", {124'h0, round}, 128'd1);
    checkOutput("r1_key", nextkey, FIPS_R1);

    // Held add: back-to-back keys up to the last round, then ignored.
    applyStimulus(1'b1, 1'b0, FIPS_KEY);
    tick();
    applyStimulus(1'b0, 1'b1, 128'h0);
    cycles = 0;
    while (!(round == 4'd10 && complete) && cycles < 200) begin
      tick();
      cycles++;
    end
    checkOutput("r10_cycles", 128'(cycles), 128'd70);
    checkOutput("r10_key", nextkey, FIPS_R10);
    repeat (20) tick();
    checkOutput("r10_hold_round", {124'h0, round}, 128'd10);
    checkOutput("r10_hold_key", nextkey, FIPS_R10);
    checkOutput("r10_hold_busy", {127'h0, busy}, 128'h0);
    applyStimulus(1'b0, 1'b0, 128'h0);

    // Abort during SUB1 of round 3.
    applyStimulus(1'b1, 1'b0, FIPS_KEY);
    tick();
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b0, 1'b1, 128'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 128'h0);
      waitComplete("abort_setup");
    end
    applyStimulus(1'b0, 1'b1, 128'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 128'h0);
    tick();
    applyStimulus(1'b1, 1'b0, ABORT_KEY);
    tick();
    applyStimulus(1'b0, 1'b0, 128'h0);
    checkOutput("abort_round", {124'h0, round}, 128'd0);
    checkOutput("abort_key", nextkey, ABORT_KEY);
    checkOutput("abort_complete", {127'h0, complete}, 128'h1);

    // start and add together: reload only.
    applyStimulus(1'b0, 1'b1, 128'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 128'h0);
    waitComplete("collide_setup");
    applyStimulus(1'b1, 1'b1, FIPS_KEY);
    tick();
    applyStimulus(1'b0, 1'b0, 128'h0);
    checkOutput("collide_round", {124'h0, round}, 128'd0);
    checkOutput("collide_busy", {127'h0, busy}, 128'h0);

    // add pulse while busy is not queued.
    applyStimulus(1'b0, 1'b1, 128'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 128'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 128'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 128'h0);
    waitComplete("busy_add");
    repeat (10) tick();
    checkOutput("busy_add_round", {124'h0, round}, 128'd1);

    // Asynchronous reset in SUB2.
    applyStimulus(1'b0, 1'b1, 128'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 128'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_key", nextkey, 128'h0);
    checkOutput("rst_round", {124'h0, round}, 128'd0);
    checkOutput("rst_busy", {127'h0, busy}, 128'h0);
    checkOutput("rst_complete", {127'h0, complete}, 128'h0);
    reset = 1'b1;
    repeat (5) tick();
    checkOutput("rst_idle", {127'h0, complete}, 128'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
                    {$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    applyStimulus(1'b0, 1'b0, 128'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/aes_key_scheduler.md
Name: aes_key_scheduler

Overview:
On-the-fly AES-128 round-key generator. It serves the round FSM one key per request over a `nextkey`/`complete`/`add` handshake. It owns no S-box: it time-shares a single external synchronous S-box port, issuing the four SubWord lookups one byte per cycle. It sits between the key input register and the AES round controller, and replaces any full 11-key expansion RAM.

Parameters:
NROUNDS, 10, number of round keys generated after the cipher key (rcon table indexed 1..NROUNDS)

Ports:
int_osc  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  1-cycle pulse: capture key, restart schedule at round 0
key  input  128  cipher key; byte 0 = key[127:120], word w0 = key[127:96]
add  input  1  request next round key; accepted only when complete=1 and round<NROUNDS
sbox_addr  output  8  byte presented to the shared S-box
sbox_data  input  8  S-box result; valid exactly 1 cycle after sbox_addr
nextkey  output  128  current round key
complete  output  1  level: nextkey valid and stable
round  output  4  index of the key currently on nextkey (0..NROUNDS)
busy  output  1  high while a key computation is in progress

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; nextkey=0, complete=0, round=0, busy=0, sbox_addr=0, internal subword register=0.
- States: IDLE, READY, SUB0, SUB1, SUB2, SUB3, CAP, CALC.
- IDLE:
  - complete=0.
  - start → READY at the next edge; nextkey<=key, round<=0.
- READY:
  - complete=1, busy=0.
  - add with round<NROUNDS → SUB0; complete falls in the next cycle.
  - add with round==NROUNDS → ignored; stay READY with nextkey held.
- SUB0..SUB3:
  - sbox_addr = RotWord(w3) byte k, i.e. w3 bytes 1,2,3,0 respectively (w3 = nextkey[31:0], byte 0 = nextkey[31:24]).
  - busy=1.
  - The byte returned in sbox_data is captured on the edge leaving the following state: SUB1..SUB3 capture bytes 0..2, CAP captures byte 3.
- CAP:
  - sbox_addr holds the last address.
  - Captures the final S-box byte.
- CALC (all computation in one cycle):
  - temp = SubWord ^ {rcon[round+1], 24'h0}.
  - w4=w0^temp, w5=w1^w4, w6=w2^w5, w7=w3^w6.
  - nextkey<={w4,w5,w6,w7}; round<=round+1; next state READY.
- Latency:
  - add accepted at edge t → complete=1 with the new key visible after edge t+6.
  - SUB0,SUB1,SUB2,SUB3,CAP and CALC each take one cycle.
  - nextkey changes only at the CALC→READY edge and on start.
- rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- sbox_addr = 0 in IDLE and READY.
- Mid-computation events:
  - start in any state (including SUB*/CALC) aborts the computation, reloads key, round=0, next state READY.
  - start and add in the same cycle: start wins, add dropped.
  - add while complete=0 is ignored; it is not queued.
- Asynchronous reset mid-operation returns to IDLE immediately.
- A held-high add yields back-to-back keys: one new key every 7 cycles (1 READY cycle + 6-cycle computation) until round==NROUNDS.
- round never exceeds NROUNDS; no wrap-around.

Test Plan:
- Reset: assert reset=0 mid-SUB2 → nextkey=0, complete=0, round=0, busy=0 immediately; release, no start → stays IDLE.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, then add pulse → nextkey=2b7e...4f3c at round 0; after 6 cycles complete=1, round=1, nextkey=a0fafe1788542cb123a339392a6c7605.
- Hold add high from round 0 → round 10 key d014f9a8c9ee2589e13f0cc8b6630ca6 appears; complete stays high, round=10; further add ignored for 20 cycles.
- S-box port: check the sbox_addr sequence for round 1 = 0xcf,0x4f,0x3c,0x09 over SUB0..SUB3. Bench model returns data with exactly 1-cycle latency.
- Abort: start with a new key (000102...0f) during SUB1 of round 3 → next cycle round=0, nextkey=000102030405060708090a0b0c0d0e0f, complete=1.
- Collisions: start and add in the same cycle → reload only, round=0. add pulse while busy → no effect on the final round count.
